// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction fetch unit.
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head word is visible on data_o while not empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = pop_i && !w_empty;
   // A full FIFO may still accept a word when the head leaves in the same cycle.
   assign w_do_push = push_i && (!w_full || w_do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push && !flush_i) r_mem[r_wptr] <= data_i;
   end

   assign data_o  = r_mem[r_rptr];
   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign count_o = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response capture into a
// prefetch buffer, and redirect handling that discards responses to stale requests.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic            imem_req_valid_o,
   input  logic            imem_req_ready_i,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o
);

   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned SW = CW + 1;

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;

   logic [2*XLEN-1:0] w_head;
   logic [CW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_instr_valid;
   logic              w_credit_ok;
   logic              w_req_valid;
   logic              w_req_fire;
   logic              w_rsp_in;
   logic              w_push;
   logic              w_pop;
   logic [CW-1:0]     w_left_after_redirect;
   logic [XLEN-1:0]   w_redirect_pc;
   logic              w_unused_pc_lsb;

   assign w_redirect_pc   = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

   // Responses with nothing outstanding (e.g. from before reset) are ignored.
   assign w_rsp_in    = imem_rsp_valid_i && (r_outstanding != '0);
   assign w_credit_ok = (SW'(r_outstanding) + SW'(w_count)) < SW'(DEPTH);
   assign w_req_valid = rst_ni && (r_state == FETCH) && !redirect_i && w_credit_ok;
   assign w_req_fire  = w_req_valid && imem_req_ready_i;

   assign w_instr_valid = rst_ni && !w_empty;
   assign w_push        = w_rsp_in && (r_state == FETCH) && !redirect_i;
   assign w_pop         = w_instr_valid && instr_ready_i && !redirect_i;

   assign w_left_after_redirect = r_outstanding - CW'(w_rsp_in);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state       <= FETCH;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (redirect_i) begin
         r_fetch_pc    <= w_redirect_pc;
         r_rsp_pc      <= w_redirect_pc;
         r_outstanding <= w_left_after_redirect;
         r_drop_cnt    <= w_left_after_redirect;
         r_state       <= (w_left_after_redirect != '0) ? FLUSH : FETCH;
      end else begin
         if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
         if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(4);
         unique case ({w_req_fire, w_rsp_in})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         unique case (r_state)
            FETCH: r_state <= FETCH;
            FLUSH: begin
               if (w_rsp_in) begin
                  r_drop_cnt <= r_drop_cnt - CW'(1);
                  if (r_drop_cnt == CW'(1)) r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (redirect_i),
      .push_i  (w_push),
      .data_i  ({r_rsp_pc, imem_rsp_data_i}),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   logic w_unused_full;
   assign w_unused_full = w_full;

   assign imem_req_valid_o = w_req_valid;
   assign imem_req_addr_o  = r_fetch_pc;
   assign instr_valid_o    = w_instr_valid;
   assign instr_pc_o       = w_head[2*XLEN-1:XLEN];
   assign instr_o          = w_head[XLEN-1:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/address width.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port imem_req_valid_o  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready_i  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr_o  output  XLEN  fetch address, bits [1:0] always 0.
REQ-009 SHALL have port imem_rsp_valid_i  input  1  response valid, in order, always accepted.
REQ-010 SHALL have port imem_rsp_data_i  input  XLEN  fetched instruction.
REQ-011 SHALL have port redirect_i  input  1  control-flow change (branch/jump taken).
REQ-012 SHALL have port redirect_pc_i  input  XLEN  redirect target.
REQ-013 SHALL have port instr_valid_o  output  1  buffer head valid.
REQ-014 SHALL have port instr_ready_i  input  1  decode consumes head.
REQ-015 SHALL have port instr_o  output  XLEN  head instruction.
REQ-016 SHALL have port instr_pc_o  output  XLEN  PC of head instruction.

Function
REQ-017 SHALL keep fetch_pc; request handshake (valid && ready) advances it by 4, wrapping modulo 2^XLEN.
REQ-018 SHALL assert imem_req_valid_o only in state FETCH, redirect_i low, and (outstanding + occupancy) < DEPTH; occupancy counted before this cycle's pop.
REQ-019 SHALL keep imem_req_valid_o and imem_req_addr_o stable while valid high and ready low, unless redirect_i is high.
REQ-020 SHALL count outstanding requests (0..DEPTH): +1 on request handshake, -1 on response, both same cycle -> unchanged.
REQ-021 SHALL push each accepted response into the buffer with its PC from rsp_pc, which is loaded with the address of each redirect/reset and advances by 4 per pushed response.
REQ-022 SHALL present a pushed instruction on instr_o/instr_pc_o with instr_valid_o high no earlier than the cycle after the response (1-cycle latency, no bypass).
REQ-023 SHALL pop the head when instr_valid_o && instr_ready_i; push and pop same cycle both occur, occupancy unchanged.
REQ-024 SHALL never overflow: REQ-018 credit rule makes push-when-full impossible; empty buffer drives instr_valid_o=0.
REQ-025 SHALL on redirect_i: clear buffer (pop ignored), load fetch_pc and rsp_pc with redirect_pc_i with bits [1:0] forced to 0, set drop_cnt = outstanding - imem_rsp_valid_i.
REQ-026 SHALL discard any response arriving in the redirect cycle.
REQ-027 SHALL FSM states FETCH, FLUSH: FETCH->FLUSH on redirect with drop_cnt>0; FLUSH decrements drop_cnt per response, discarding it, no requests; FLUSH->FETCH when last stale response arrives (request may issue next cycle).
REQ-028 SHALL on redirect during FLUSH recompute drop_cnt per REQ-025 and stay/return per REQ-027.
REQ-029 SHALL give redirect_i priority over every simultaneous event.

Reset
REQ-030 SHALL on rst_ni low at a clock edge: fetch_pc=rsp_pc=RESET_PC, buffer empty, outstanding=0, drop_cnt=0, state FETCH, regardless of in-flight operation.
REQ-031 SHALL drive imem_req_valid_o=0 and instr_valid_o=0 during reset; first request, address RESET_PC, in first cycle after release.
REQ-032 SHALL drop responses to requests issued before reset (memory is reset together).

Structure
REQ-033 SHALL define fetch_state_e (FETCH, FLUSH) in riscv_pkg; RESET_PC default constant there too.
REQ-034 SHALL implement buffer as sub-module sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count), storing {pc, instr}.

Verification
REQ-035 SHALL verify: ready=1, 1-cycle memory, ready_i=1 -> PCs 0,4,8,12 out in order, instr matches memory, one instruction per cycle steady state.
REQ-036 SHALL verify: instr_ready_i=0 for 10 cycles -> exactly DEPTH=4 requests total, stall holds, no loss on resume.
REQ-037 SHALL verify: redirect to 0x103 with 2 outstanding -> next request addr 0x100, 2 responses dropped, first output PC 0x100.
REQ-038 SHALL verify: redirect in same cycle as response and pop -> response dropped, buffer empty next cycle, drop_cnt = outstanding-1.
REQ-039 SHALL verify: fetch_pc 0xFFFF_FFFC -> next request addr 0x0000_0000.
REQ-040 SHALL verify: reset asserted during FLUSH -> next cycle state FETCH, outputs 0, first request addr RESET_PC.
